// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the CNN output stages.
package cnn_pkg;

    localparam int N_OUT       = 10;     // class scores, digits 0-9
    localparam int DATA_W      = 8;      // activation / weight / score width
    localparam int SCORE_AW    = 10;     // score memory address width
    localparam int FEAT_AW     = 10;     // activation memory address width
    localparam int SCORE_DEPTH = N_OUT;  // score words read back by the argmax stage

    // FC2 controller states
    typedef enum logic [3:0] {
        FC_IDLE      = 4'd0,
        FC_READ_REQ  = 4'd1,
        FC_WAIT_MEM  = 4'd2,
        FC_MAC       = 4'd3,
        FC_BIAS_REQ  = 4'd4,
        FC_BIAS_WAIT = 4'd5,
        FC_BIAS_ADD  = 4'd6,
        FC_WRITE     = 4'd7,
        FC_FINISH    = 4'd8
    } fc_state_e;

    // First weight ROM word of neuron n: each row holds n_in weights plus one bias.
    function automatic int row_base(input int n, input int n_in);
        return n * (n_in + 1);
    endfunction

endpackage

// File: rtl/fc_mac_datapath.sv
// FC2 accumulator: unsigned-by-signed MAC, pre-scaled bias add, and
// requantization of the accumulator to a saturated 8-bit unsigned score.
module fc_mac_datapath
    import cnn_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int SHIFT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              mac_i,
    input  logic              bias_add_i,
    input  logic [DATA_W-1:0] feat_data_i,
    input  logic [DATA_W-1:0] w_data_i,
    output logic [DATA_W-1:0] score_o
);

    // Unsigned 8-bit times signed 8-bit always fits in 17 signed bits.
    localparam int PROD_W = 2 * DATA_W + 1;

    logic signed [PROD_W-1:0] feat_s;
    logic signed [PROD_W-1:0] w_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  mac_term;
    logic signed [ACC_W-1:0]  bias_term;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  shifted;

    assign feat_s    = {{(PROD_W - DATA_W){1'b0}}, feat_data_i};
    assign w_s       = {{(PROD_W - DATA_W){w_data_i[DATA_W-1]}}, w_data_i};
    assign prod      = feat_s * w_s;
    assign mac_term  = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    // Bias lives at the same scale as the requantized score, so lift it by SHIFT.
    assign bias_term = {{(ACC_W - DATA_W - SHIFT){w_data_i[DATA_W-1]}}, w_data_i, {SHIFT{1'b0}}};

    // Accumulator next value: clear wins, then MAC, then bias add.
    always_comb begin
        // NOTE: give every combinational output a default first so no latch is inferred.
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (mac_i) begin
            acc_d = acc_q + mac_term;
        end else if (bias_add_i) begin
            acc_d = acc_q + bias_term;
        end
    end

    // Accumulator register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Arithmetic shift floors toward minus infinity; clamp into 0..255.
    assign shifted = acc_q >>> SHIFT;

    // Saturating conversion of the shifted accumulator to an unsigned byte.
    always_comb begin
        score_o = shifted[DATA_W-1:0];
        if (shifted[ACC_W-1]) begin
            score_o = '0;
        end else if (|shifted[ACC_W-2:DATA_W]) begin
            score_o = '1;
        end
    end

endmodule

// File: rtl/fc_score_writer.sv
// FC2 output engine: walks the weight ROM row by row, accumulates ten class
// scores and writes them to score memory addresses 0..9, then raises done.
module fc_score_writer
    import cnn_pkg::*;
#(
    parameter int N_IN  = 32,
    parameter int SHIFT = 7,
    parameter int ACC_W = 24,
    parameter int W_AW  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [FEAT_AW-1:0]  feat_addr,
    input  logic [DATA_W-1:0]   feat_data,
    output logic [W_AW-1:0]     w_addr,
    input  logic [DATA_W-1:0]   w_data,
    output logic                wr_en,
    output logic [SCORE_AW-1:0] wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                done
);

    localparam int I_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int N_W = $clog2(N_OUT);

    fc_state_e           state_q, state_d;
    logic [N_W-1:0]      n_q, n_d;
    logic [I_W-1:0]      i_q, i_d;
    logic [FEAT_AW-1:0]  feat_addr_q, feat_addr_d;
    logic [W_AW-1:0]     w_addr_q, w_addr_d;
    logic                wr_en_q, wr_en_d;
    logic [SCORE_AW-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                done_q, done_d;

    logic                acc_clear, acc_mac, acc_bias;
    logic [DATA_W-1:0]   score;
    logic [W_AW-1:0]     w_base;

    assign w_base = W_AW'(row_base(int'(n_q), N_IN));

    fc_mac_datapath #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (acc_clear),
        .mac_i       (acc_mac),
        .bias_add_i  (acc_bias),
        .feat_data_i (feat_data),
        .w_data_i    (w_data),
        .score_o     (score)
    );

    // Next-state, counters, registered outputs and datapath controls.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        i_d         = i_q;
        feat_addr_d = feat_addr_q;
        w_addr_d    = w_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = done_q;
        acc_clear   = 1'b0;
        acc_mac     = 1'b0;
        acc_bias    = 1'b0;

        case (state_q)
            FC_IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    n_d       = '0;
                    i_d       = '0;
                    acc_clear = 1'b1;
                    state_d   = FC_READ_REQ;
                end
            end
            FC_READ_REQ: begin
                feat_addr_d = FEAT_AW'(i_q);
                w_addr_d    = w_base + W_AW'(i_q);
                state_d     = FC_WAIT_MEM;
            end
            FC_WAIT_MEM: begin
                state_d = FC_MAC;
            end
            FC_MAC: begin
                acc_mac = 1'b1;
                if (i_q == I_W'(N_IN - 1)) begin
                    state_d = FC_BIAS_REQ;
                end else begin
                    i_d     = i_q + I_W'(1);
                    state_d = FC_READ_REQ;
                end
            end
            FC_BIAS_REQ: begin
                w_addr_d = w_base + W_AW'(N_IN);
                state_d  = FC_BIAS_WAIT;
            end
            FC_BIAS_WAIT: begin
                state_d = FC_BIAS_ADD;
            end
            FC_BIAS_ADD: begin
                acc_bias = 1'b1;
                state_d  = FC_WRITE;
            end
            FC_WRITE: begin
                wr_data_d = score;
                wr_addr_d = SCORE_AW'(n_q);
                wr_en_d   = 1'b1;
                acc_clear = 1'b1;
                i_d       = '0;
                if (n_q == N_W'(N_OUT - 1)) begin
                    state_d = FC_FINISH;
                end else begin
                    n_d     = n_q + N_W'(1);
                    state_d = FC_READ_REQ;
                end
            end
            FC_FINISH: begin
                done_d = 1'b1;
                if (!start) begin
                    state_d = FC_IDLE;
                end
            end
            default: begin
                state_d = FC_IDLE;
            end
        endcase
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FC_IDLE;
            n_q         <= '0;
            i_q         <= '0;
            feat_addr_q <= '0;
            w_addr_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            i_q         <= i_d;
            feat_addr_q <= feat_addr_d;
            w_addr_q    <= w_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
        end
    end

    assign feat_addr = feat_addr_q;
    assign w_addr    = w_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fc_score_writer.sv
// Bench for fc_score_writer: synchronous activation / weight memories, a
// write monitor, and a reference model that evaluates the ten dot products
// directly from the memory contents.
module tb_fc_score_writer;

    localparam int N_IN  = 32;
    localparam int SHIFT = 7;
    localparam int ACC_W = 24;
    localparam int W_AW  = 10;
    localparam int N_OUT = 10;
    localparam int PER   = 3 * N_IN + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  feat_addr;
    logic [7:0]  feat_data = '0;
    logic [9:0]  w_addr;
    logic [7:0]  w_data = '0;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        done;

    logic [7:0]  feat_mem [0:1023];
    logic [7:0]  w_mem    [0:1023];

    int n_checks = 0;
    int n_bad    = 0;

    int edge_cnt = 0;
    int t0       = 0;
    int wa_q[$];
    int wd_q[$];
    int we_q[$];
    bit done_seen = 1'b0;
    int done_edge = -1;
    int overlap   = 0;

    fc_score_writer #(
        .N_IN  (N_IN),
        .SHIFT (SHIFT),
        .ACC_W (ACC_W),
        .W_AW  (W_AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .feat_addr (feat_addr),
        .feat_data (feat_data),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Memories with one cycle of read latency; edge counter.
    always @(posedge clk) begin
        feat_data <= feat_mem[feat_addr];
        w_data    <= w_mem[w_addr];
        edge_cnt  <= edge_cnt + 1;
    end

    // Monitor: log every write and the first edge done is seen, relative to t0.
    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(int'(wr_addr));
            wd_q.push_back(int'(wr_data));
            we_q.push_back(edge_cnt - t0);
            if (done) overlap++;
        end
        if (done && !done_seen) begin
            done_seen = 1'b1;
            done_edge = edge_cnt - t0;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference score of neuron n: dot product plus bias*2^SHIFT, floored, clamped.
    function automatic int model_score(input int n);
        int base = n * (N_IN + 1);
        int sum  = 0;
        int r;
        for (int i = 0; i < N_IN; i++)
            sum += int'(feat_mem[i]) * int'($signed(w_mem[base + i]));
        sum += int'($signed(w_mem[base + N_IN])) * (1 << SHIFT);
        r = sum >>> SHIFT;
        if (r < 0)   return 0;
        if (r > 255) return 255;
        return r;
    endfunction

    task automatic load(input int kind);
        for (int k = 0; k < 1024; k++) begin
            feat_mem[k] = '0;
            w_mem[k]    = '0;
        end
        for (int i = 0; i < N_IN; i++) begin
            case (kind)
                0:       feat_mem[i] = 8'd2;
                1, 2:    feat_mem[i] = 8'd255;
                3:       feat_mem[i] = 8'd0;
                default: feat_mem[i] = 8'($urandom);
            endcase
        end
        for (int n = 0; n < N_OUT; n++) begin
            for (int i = 0; i < N_IN; i++) begin
                case (kind)
                    0:       w_mem[n*(N_IN+1)+i] = 8'(4 * n);
                    1:       w_mem[n*(N_IN+1)+i] = 8'd127;
                    2:       w_mem[n*(N_IN+1)+i] = 8'h80;
                    5:       w_mem[n*(N_IN+1)+i] = 8'(int'($urandom_range(0, 16)) - 8);
                    default: w_mem[n*(N_IN+1)+i] = 8'($urandom);
                endcase
            end
            case (kind)
                3:       w_mem[n*(N_IN+1)+N_IN] = 8'(n - 3);
                4:       w_mem[n*(N_IN+1)+N_IN] = 8'($urandom);
                5:       w_mem[n*(N_IN+1)+N_IN] = 8'(int'($urandom_range(0, 40)) - 20);
                default: w_mem[n*(N_IN+1)+N_IN] = 8'd0;
            endcase
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        we_q.delete();
        done_seen = 1'b0;
        done_edge = -1;
        overlap   = 0;
    endtask

    // One full job: raise start (sampled at edge 0), wait for done, compare
    // all writes and timing, then exercise the start/done handshake.
    task automatic run_job(input string tag, input bit toggle);
        int exp_s[N_OUT];
        int budget = 0;
        int nw;
        for (int n = 0; n < N_OUT; n++) exp_s[n] = model_score(n);
        clear_log();
        start = 1'b1;
        t0    = edge_cnt + 1;
        while (!done_seen && budget < 3000) begin
            step();
            budget++;
            if (toggle)
                start = (edge_cnt - t0 < 950) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check({tag, " done_seen"}, int'(done_seen), 1);
        nw = wa_q.size();
        check({tag, " n_writes"}, nw, N_OUT);
        for (int j = 0; j < N_OUT && j < nw; j++) begin
            check($sformatf("%s addr[%0d]", tag, j), wa_q[j], j);
            check($sformatf("%s data[%0d]", tag, j), wd_q[j], exp_s[j]);
            // wr_en is registered at edge (j+1)*PER; memory captures it one edge later.
            check($sformatf("%s wr_edge[%0d]", tag, j), we_q[j] + 1, (j + 1) * PER + 1);
        end
        check({tag, " done_edge"}, done_edge, N_OUT * PER + 1);
        check({tag, " wr_en_with_done"}, overlap, 0);
        // Start held high: done stays, nothing new written.
        repeat (20) step();
        check({tag, " done_hold"}, int'(done), 1);
        check({tag, " no_extra_writes"}, wa_q.size(), N_OUT);
        // Drop start: FINISH -> IDLE on the next edge, done falls one edge later.
        start = 1'b0;
        step();
        check({tag, " done_after_drop"}, int'(done), 1);
        step();
        check({tag, " done_fall"}, int'(done), 0);
        repeat (5) step();
        check({tag, " idle_no_writes"}, wa_q.size(), N_OUT);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " feat_addr"}, int'(feat_addr), 0);
        check({tag, " w_addr"},    int'(w_addr),    0);
        check({tag, " wr_en"},     int'(wr_en),     0);
        check({tag, " wr_addr"},   int'(wr_addr),   0);
        check({tag, " wr_data"},   int'(wr_data),   0);
        check({tag, " done"},      int'(done),      0);
    endtask

    initial begin
        int budget;
        load(0);
        repeat (3) step();
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) step();
        check_outputs_zero("idle");

        load(0); run_job("basic", 1'b0);
        load(1); run_job("sat_hi", 1'b0);
        load(2); run_job("sat_lo", 1'b0);
        load(3); run_job("bias_only", 1'b0);
        load(4); run_job("rand_full", 1'b0);
        load(5); run_job("rand_toggle", 1'b1);

        // Reset after the third write: outputs clear, no further writes.
        load(5);
        clear_log();
        start  = 1'b1;
        t0     = edge_cnt + 1;
        budget = 0;
        while (wa_q.size() < 3 && budget < 1000) begin
            step();
            budget++;
        end
        check("midrst third_write", wa_q.size(), 3);
        rst   = 1'b1;
        start = 1'b0;
        step();
        check_outputs_zero("midrst");
        rst = 1'b0;
        repeat (400) step();
        check("midrst no_more_writes", wa_q.size(), 3);
        check("midrst done_low", int'(done), 0);
        run_job("after_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
